// File: rtl/store_buffer.sv
// Posted-write store buffer between the MEM stage and a single-port 16-bit data memory.
// Stores queue in a small FIFO and drain when the port is idle; loads forward from the youngest exact match.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AW-1:0]              cpu_addr,
    input  logic [DW-1:0]              cpu_wdata,
    input  logic                       cpu_wr,
    input  logic                       cpu_rd,
    output logic [DW-1:0]              cpu_rdata,
    output logic                       cpu_stall,
    output logic                       flushed,
    output logic [$clog2(DEPTH):0]     count,
    output logic [AW-1:0]              mem_addr,
    output logic [DW-1:0]              mem_wdata,
    output logic                       mem_wr,
    input  logic                       mem_ready,
    input  logic [DW-1:0]              mem_rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_reg [DEPTH];
    logic [DW-1:0] data_reg [DEPTH];
    logic [PW-1:0] head_reg, head_next;
    logic [PW-1:0] tail_reg, tail_next;
    logic [CW-1:0] count_reg, count_next;

    logic [PW-1:0]    age [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] match;
    logic [DEPTH-1:0] near;

    logic          rd_eff;
    logic          hit;
    logic          overlap;
    logic          load_port;
    logic          full;
    logic          push;
    logic          pop;
    logic [DW-1:0] fwd_data;
    logic [PW-1:0] fwd_idx;

    // A simultaneous load+store is treated as a store.
    assign rd_eff = cpu_rd & ~cpu_wr;

    // Per-entry validity from its age relative to head, plus exact and adjacent-byte address compares.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign age[gi]   = PW'(gi) - head_reg;
            assign valid[gi] = {1'b0, age[gi]} < count_reg;
            assign match[gi] = rd_eff & valid[gi] & (addr_reg[gi] == cpu_addr);
            assign near[gi]  = rd_eff & valid[gi] &
                               ((addr_reg[gi] == cpu_addr + AW'(1)) ||
                                (addr_reg[gi] == cpu_addr - AW'(1)));
        end
    endgenerate

    assign hit     = |match;
    assign overlap = |near;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        fwd_data = '0;
        fwd_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_reg + PW'(k);
            if (match[fwd_idx]) begin
                fwd_data = data_reg[fwd_idx];
            end
        end
    end

    assign full      = (count_reg == CW'(DEPTH));
    assign load_port = rd_eff & ~hit & ~overlap;

    always_comb begin
        mem_wr    = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = data_reg[head_reg];
        if (!rst && !load_port && count_reg != '0) begin
            mem_wr   = 1'b1;
            mem_addr = addr_reg[head_reg];
        end
    end

    assign pop = mem_wr & mem_ready;

    always_comb begin
        cpu_stall = 1'b0;
        if (!rst) begin
            cpu_stall = (cpu_wr & full & ~pop) | overlap | (load_port & ~mem_ready);
        end
    end

    assign push      = ~rst & cpu_wr & ~cpu_stall;
    assign cpu_rdata = hit ? fwd_data : mem_rdata;
    assign count     = count_reg;
    assign flushed   = (count_reg == '0);

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (pop) begin
            head_next = head_reg + PW'(1);
        end
        if (push) begin
            tail_next = tail_reg + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Entry payload is never cleared; validity comes solely from head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_reg[tail_reg] <= cpu_addr;
            data_reg[tail_reg] <= cpu_wdata;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected memory writes and load data are queued by the
// stimulus and consumed by a monitor whenever the DUT commits a write or completes a load.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [15:0] cpu_rdata;
    logic        cpu_stall;
    logic        flushed;
    logic [2:0]  count;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_wr;
    logic        mem_ready;
    logic [15:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t         wq[$];
    logic [15:0] lq[$];
    wr_t         wexp;
    logic [15:0] lexp;

    always #5 clk = ~clk;

    // Memory read data is a fixed function of the address the DUT presents.
    assign mem_rdata = mem_addr ^ 16'hC3C3;

    store_buffer #(.DEPTH(4), .AW(16), .DW(16)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .flushed(flushed), .count(count),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_wr(input logic [15:0] a, input logic [15:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        wq.push_back(e);
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d);
        cpu_wr    = 1'b1;
        cpu_rd    = 1'b0;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    task automatic idle();
        cpu_wr = 1'b0;
        cpu_rd = 1'b0;
    endtask

    task automatic drain();
        mem_ready = 1'b1;
        idle();
        for (int n = 0; n < 20 && count != 3'd0; n++) begin
            step();
        end
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_wq_empty", 32'(wq.size()), 32'd0);
    endtask

    // Monitor: consume one expectation per committed write and per completed load.
    always @(negedge clk) begin
        assert (!(cpu_rd && cpu_wr)) else $error("cpu_rd and cpu_wr asserted together");
        if (!rst && mem_wr && mem_ready) begin
            if (wq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%h data=%h expected none", mem_addr, mem_wdata);
            end else begin
                wexp = wq.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(wexp.a));
                chk("wr_data", 32'(mem_wdata), 32'(wexp.d));
            end
        end
        if (!rst && cpu_rd && !cpu_wr && !cpu_stall) begin
            if (lq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_load: got data=%h expected none", cpu_rdata);
            end else begin
                lexp = lq.pop_front();
                chk("ld_data", 32'(cpu_rdata), 32'(lexp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; mem_ready = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_wr = 1'b0; cpu_rd = 1'b0;
        step();
        #1;
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_flushed", 32'(flushed), 32'd1);

        // Single store then drain.
        store(16'h0010, 16'h1111);
        exp_wr(16'h0010, 16'h1111);
        #1;
        chk("t1_stall", 32'(cpu_stall), 32'd0);
        chk("t1_no_same_cycle_drain", 32'(mem_wr), 32'd0);
        step();
        idle();
        #1;
        chk("t1_count1", 32'(count), 32'd1);
        chk("t1_mem_wr", 32'(mem_wr), 32'd1);
        chk("t1_mem_addr", 32'(mem_addr), 32'h0010);
        chk("t1_mem_wdata", 32'(mem_wdata), 32'h1111);
        step();
        #1;
        chk("t1_count0", 32'(count), 32'd0);
        chk("t1_flushed", 32'(flushed), 32'd1);

        // Two stores to the same address, load forwards the younger.
        mem_ready = 1'b0;
        store(16'h0040, 16'h1111); exp_wr(16'h0040, 16'h1111); step();
        store(16'h0040, 16'h2222); exp_wr(16'h0040, 16'h2222); step();
        cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 16'h0040;
        lq.push_back(16'h2222);
        #1;
        chk("t2_stall", 32'(cpu_stall), 32'd0);
        chk("t2_mem_wr", 32'(mem_wr), 32'd1);
        chk("t2_count", 32'(count), 32'd2);
        step();
        drain();

        // Fill to DEPTH, fifth store stalls until a pop frees a slot on the same edge.
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            store(16'(2 * i), 16'h3000 + 16'(i));
            exp_wr(16'(2 * i), 16'h3000 + 16'(i));
            step();
        end
        store(16'h0008, 16'h3004);
        #1;
        chk("t3_full_count", 32'(count), 32'd4);
        chk("t3_full_stall", 32'(cpu_stall), 32'd1);
        mem_ready = 1'b1;
        exp_wr(16'h0008, 16'h3004);
        #1;
        chk("t3_pop_push_stall", 32'(cpu_stall), 32'd0);
        step();
        idle();
        #1;
        chk("t3_count_held", 32'(count), 32'd4);
        drain();

        // Partial overlap stalls the load until the overlapping entry drains.
        mem_ready = 1'b0;
        store(16'h0041, 16'hABCD); exp_wr(16'h0041, 16'hABCD); step();
        cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_addr = 16'h0040;
        #1;
        chk("t4_stall_a", 32'(cpu_stall), 32'd1);
        step();
        #1;
        chk("t4_stall_b", 32'(cpu_stall), 32'd1);
        mem_ready = 1'b1;
        lq.push_back(16'h0040 ^ 16'hC3C3);
        #1;
        chk("t4_stall_drain", 32'(cpu_stall), 32'd1);
        chk("t4_drain_wr", 32'(mem_wr), 32'd1);
        step();
        #1;
        chk("t4_port_wr", 32'(mem_wr), 32'd0);
        chk("t4_port_addr", 32'(mem_addr), 32'h0040);
        chk("t4_port_stall", 32'(cpu_stall), 32'd0);
        step();
        idle();

        // Load from an empty buffer waits on mem_ready.
        mem_ready = 1'b0;
        cpu_rd = 1'b1; cpu_addr = 16'h0100;
        lq.push_back(16'h0100 ^ 16'hC3C3);
        #1;
        chk("t5_stall_1", 32'(cpu_stall), 32'd1);
        step();
        #1;
        chk("t5_stall_2", 32'(cpu_stall), 32'd1);
        step();
        mem_ready = 1'b1;
        #1;
        chk("t5_stall_3", 32'(cpu_stall), 32'd0);
        chk("t5_addr", 32'(mem_addr), 32'h0100);
        step();
        idle();

        // Reset mid-drain discards remaining entries.
        mem_ready = 1'b0;
        store(16'h0200, 16'h5000); step();
        store(16'h0202, 16'h5001); step();
        store(16'h0204, 16'h5002); step();
        idle();
        mem_ready = 1'b1;
        exp_wr(16'h0200, 16'h5000);
        step();
        rst = 1'b1;
        #1;
        chk("t6_rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("t6_rst_stall", 32'(cpu_stall), 32'd0);
        chk("t6_rst_flushed_pre", 32'(flushed), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_flushed", 32'(flushed), 32'd1);
        for (int n = 0; n < 5; n++) begin
            step();
        end
        chk("end_wq_empty", 32'(wq.size()), 32'd0);
        chk("end_lq_empty", 32'(lq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
